// File: rtl/somador_subtrator_serial.sv
// somador_subtrator_serial
// Digit-serial adder/subtractor. It processes DIGITO bits per clock, starting with
// the LSB slice, and uses N = LARGURA/DIGITO computation cycles. Operand B is
// zero-extended and then XORed with modo_sub. Results are registered and become
// visible only in the FIM cycle, together with a one-cycle pronto strobe.
module somador_subtrator_serial #(
    parameter int LARGURA   = 8,
    parameter int LARGURA_B = 4,
    parameter int DIGITO    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inicio,
    input  logic                 modo_sub,
    input  logic                 cin_inicial,
    input  logic                 acumular,
    input  logic [LARGURA-1:0]   a,
    input  logic [LARGURA_B-1:0] b,
    output logic [LARGURA-1:0]   s,
    output logic                 cout,
    output logic                 ov,
    output logic                 zero,
    output logic                 ocupado,
    output logic                 pronto
);

    localparam int N  = LARGURA / DIGITO;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {OCIOSO, CALCULA, FIM} estado_t;

    estado_t             estado_q;
    logic [LARGURA-1:0]  a_q;        // operand A, shifted right one slice per cycle
    logic [LARGURA-1:0]  b_q;        // operand B' (already inverted for subtract), shifted likewise
    logic [LARGURA-1:0]  parcial_q;  // result slices, filled from the top down
    logic [LARGURA-1:0]  s_q;
    logic                carry_q;
    logic                cout_q;
    logic                ov_q;
    logic                zero_q;
    logic                ocupado_q;
    logic                pronto_q;
    logic [CW-1:0]       cnt_q;

    logic [DIGITO:0]     soma_fatia_d;
    logic                carry_msb_d;  // carry into the top bit of the current slice
    logic [LARGURA-1:0]  parcial_d;
    logic [LARGURA-1:0]  b_ext_d;

    // Slice adder: sum of the current low slices plus the stored carry, and the partial result shifted in
    always_comb begin
        soma_fatia_d = {1'b0, a_q[DIGITO-1:0]} + {1'b0, b_q[DIGITO-1:0]}
                     + {{DIGITO{1'b0}}, carry_q};
        carry_msb_d  = a_q[DIGITO-1] ^ b_q[DIGITO-1] ^ soma_fatia_d[DIGITO-1];
        parcial_d    = (parcial_q >> DIGITO)
                     | (LARGURA'(soma_fatia_d[DIGITO-1:0]) << (LARGURA - DIGITO));
        b_ext_d      = LARGURA'(b) ^ {LARGURA{modo_sub}};
    end

    // Control FSM plus datapath registers; the visible outputs change only on entry to FIM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q  <= OCIOSO;
            a_q       <= '0;
            b_q       <= '0;
            parcial_q <= '0;
            s_q       <= '0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
            ov_q      <= 1'b0;
            zero_q    <= 1'b0;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (estado_q)
                OCIOSO: begin
                    pronto_q <= 1'b0;
                    if (inicio) begin
                        // In accumulate mode, A is the result currently held in s_q.
                        a_q       <= acumular ? s_q : a;
                        b_q       <= b_ext_d;
                        carry_q   <= cin_inicial;
                        parcial_q <= '0;
                        cnt_q     <= '0;
                        ocupado_q <= 1'b1;
                        estado_q  <= CALCULA;
                    end
                end
                CALCULA: begin
                    a_q       <= a_q >> DIGITO;
                    b_q       <= b_q >> DIGITO;
                    carry_q   <= soma_fatia_d[DIGITO];
                    parcial_q <= parcial_d;
                    cnt_q     <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        s_q      <= parcial_d;
                        cout_q   <= soma_fatia_d[DIGITO];
                        ov_q     <= carry_msb_d ^ soma_fatia_d[DIGITO];
                        zero_q   <= (parcial_d == '0);
                        pronto_q <= 1'b1;
                        estado_q <= FIM;
                    end
                end
                FIM: begin
                    pronto_q  <= 1'b0;
                    ocupado_q <= 1'b0;
                    estado_q  <= OCIOSO;
                end
                default: begin
                    pronto_q  <= 1'b0;
                    ocupado_q <= 1'b0;
                    estado_q  <= OCIOSO;
                end
            endcase
        end
    end

    assign s       = s_q;
    assign cout    = cout_q;
    assign ov      = ov_q;
    assign zero    = zero_q;
    assign ocupado = ocupado_q;
    assign pronto  = pronto_q;

endmodule

// File: tb/tb_somador_subtrator_serial.sv
// Testbench for somador_subtrator_serial. It runs directed and random operations and
// compares each result with an arithmetic reference model.
module tb_somador_subtrator_serial;

    localparam int LARGURA   = 8;
    localparam int LARGURA_B = 4;
    localparam int DIGITO    = 2;
    localparam int N         = LARGURA / DIGITO;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 inicio = 1'b0;
    logic                 modo_sub = 1'b0;
    logic                 cin_inicial = 1'b0;
    logic                 acumular = 1'b0;
    logic [LARGURA-1:0]   a = '0;
    logic [LARGURA_B-1:0] b = '0;
    logic [LARGURA-1:0]   s;
    logic                 cout, ov, zero, ocupado, pronto;

    int n_comp  = 0;
    int n_falha = 0;
    logic [LARGURA-1:0] s_ref = '0;

    somador_subtrator_serial #(
        .LARGURA(LARGURA), .LARGURA_B(LARGURA_B), .DIGITO(DIGITO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .inicio(inicio), .modo_sub(modo_sub),
        .cin_inicial(cin_inicial), .acumular(acumular), .a(a), .b(b),
        .s(s), .cout(cout), .ov(ov), .zero(zero), .ocupado(ocupado), .pronto(pronto)
    );

    always #5 clk = ~clk;

    task automatic checar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_comp++;
        if (obs !== esp) begin
            n_falha++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, esp);
        end
    endtask

    // Runs one operation starting at a negedge. Inputs are scrambled after latching.
    // If pulso is set, inicio is pulsed during CALCULA.
    task automatic operar(input logic [7:0] va, input logic [3:0] vb, input logic vsub,
                          input logic vcin, input logic vacc, input bit pulso);
        logic [7:0] op_a, bx;
        logic [8:0] soma;
        logic       ref_ov;
        int         k, extra;
        op_a   = vacc ? s_ref : va;
        bx     = {4'b0000, vb} ^ {8{vsub}};
        soma   = {1'b0, op_a} + {1'b0, bx} + 9'(vcin);
        ref_ov = (op_a[7] == bx[7]) && (soma[7] != op_a[7]);

        a = va; b = vb; modo_sub = vsub; cin_inicial = vcin; acumular = vacc; inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        a = 8'($urandom); b = 4'($urandom); modo_sub = 1'($urandom);
        cin_inicial = 1'($urandom); acumular = 1'($urandom);
        k = 1;
        while (!pronto && k <= 3 * N) begin
            checar("ocupado_calc", ocupado, 1);
            inicio = (pulso && k == 2) ? 1'b1 : 1'b0;
            @(negedge clk);
            k++;
        end
        inicio = 1'b0;
        checar("latencia", k, N + 1);
        checar("ocupado_fim", ocupado, 1);
        checar("s", s, soma[7:0]);
        checar("cout", cout, soma[8]);
        checar("ov", ov, ref_ov);
        checar("zero", zero, soma[7:0] == 8'h00);
        s_ref = soma[7:0];
        @(negedge clk);
        checar("pronto_1ciclo", pronto, 0);
        checar("ocupado_ocioso", ocupado, 0);
        checar("s_mantido", s, s_ref);
        if (pulso) begin
            extra = 0;
            repeat (2 * N + 4) begin
                @(negedge clk);
                if (pronto) extra++;
            end
            checar("pronto_extra", extra, 0);
        end
    endtask

    initial begin
        int extra;
        // Reset state
        repeat (2) @(negedge clk);
        checar("rst_s", s, 0);
        checar("rst_cout", cout, 0);
        checar("rst_ov", ov, 0);
        checar("rst_zero", zero, 0);
        checar("rst_ocupado", ocupado, 0);
        checar("rst_pronto", pronto, 0);
        rst_n = 1'b1;

        // Directed cases
        operar(8'h05, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
        checar("dir_s_08", s, 8'h08);
        operar(8'h05, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0);
        checar("dir_s_02", s, 8'h02);
        checar("dir_cout_1", cout, 1);
        operar(8'h7F, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        checar("dir_s_80", s, 8'h80);
        checar("dir_ov_1", ov, 1);
        operar(8'h03, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0);
        checar("dir_zero_1", zero, 1);
        operar(8'h05, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
        operar(8'hAA, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
        checar("dir_acum_17", s, 8'h17);
        operar(8'h12, 4'h7, 1'b0, 1'b1, 1'b0, 1'b1);

        // Random operations
        for (int i = 0; i < 40; i++)
            operar(8'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom_range(0, 3) == 0), 1'b0);

        // Asynchronous reset in the middle of CALCULA
        a = 8'h40; b = 4'h9; modo_sub = 1'b0; cin_inicial = 1'b0; acumular = 1'b0; inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checar("rstm_s", s, 0);
        checar("rstm_cout", cout, 0);
        checar("rstm_ov", ov, 0);
        checar("rstm_zero", zero, 0);
        checar("rstm_ocupado", ocupado, 0);
        checar("rstm_pronto", pronto, 0);
        s_ref = '0;
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (2 * N + 4) begin
            @(negedge clk);
            if (pronto || ocupado) extra++;
        end
        checar("rstm_sem_pronto", extra, 0);

        // Accumulate from s=0 right after reset; start accepted at the first rising edge
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        operar(8'hAA, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0);
        checar("acum_pos_reset", s, 8'h05);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_falha);
        $finish;
    end

endmodule

// File: doc/somador_subtrator_serial.md
SOMADOR_SUBTRATOR_SERIAL -- requirements
Module: somador_subtrator_serial

Interface
REQ-001 The module SHALL have a parameter LARGURA, default 8: width of operand A and of result s.
REQ-002 The module SHALL have a parameter LARGURA_B, default 4: width of operand B, with LARGURA_B <= LARGURA.
REQ-003 The module SHALL have a parameter DIGITO, default 2: bits processed per clock, with DIGITO dividing LARGURA.
REQ-004 Derived N = LARGURA/DIGITO SHALL be the number of computation cycles.
REQ-005 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 The module SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 The module SHALL have port inicio, input, 1 bit: start request.
REQ-009 The module SHALL have port modo_sub, input, 1 bit: 0 = add, 1 = subtract (B inverted).
REQ-010 The module SHALL have port cin_inicial, input, 1 bit: carry-in into bit 0.
REQ-011 The module SHALL have port acumular, input, 1 bit: 1 = use the current s register as operand A instead of port a.
REQ-012 The module SHALL have port a, input, LARGURA bits: operand A.
REQ-013 The module SHALL have port b, input, LARGURA_B bits: operand B.
REQ-014 The module SHALL have port s, output, LARGURA bits: registered result.
REQ-015 The module SHALL have ports cout, ov and zero, outputs, 1 bit each: carry out of the MSB, signed overflow, and s == 0.
REQ-016 The module SHALL have ports ocupado and pronto, outputs, 1 bit each: operation in progress, and one-cycle completion strobe.

Function
REQ-017 Operand B SHALL be zero-extended to LARGURA bits, then every bit, including the extension bits, XORed with modo_sub.
REQ-018 The result SHALL equal A + B' + cin_inicial modulo 2^LARGURA; cout SHALL be the carry out of bit LARGURA-1.
REQ-019 ov SHALL equal the carry into bit LARGURA-1 XOR cout.
REQ-020 The FSM SHALL have exactly three states, OCIOSO, CALCULA and FIM, with reset state OCIOSO.
REQ-021 In OCIOSO with inicio=1 at a clock edge, the block SHALL latch A (port a or register s per acumular), B', modo_sub and cin_inicial, clear its digit counter and enter CALCULA.
REQ-022 CALCULA SHALL process one DIGITO-bit slice per cycle, LSB slice first, propagating carry in an internal register, for exactly N cycles, then enter FIM.
REQ-023 ocupado SHALL be 1 in CALCULA and in FIM, and 0 in OCIOSO.
REQ-024 In FIM, s, cout, ov and zero SHALL update together, pronto SHALL be 1 for exactly that one cycle, and the FSM SHALL return to OCIOSO.
REQ-025 pronto SHALL therefore assert N+1 cycles after the cycle in which inicio was sampled; one operation SHALL complete every N+2 cycles at most.
REQ-026 inicio SHALL be ignored while ocupado=1; input changes after latching SHALL NOT affect the operation in progress.
REQ-027 s, cout, ov and zero SHALL hold their last values between completions; partial results SHALL NOT be visible on s.
REQ-028 With acumular=1, the value of s latched at the start edge SHALL be used as A, including s=0 after reset.

Reset
REQ-029 rst_n=0 SHALL, asynchronously and at any time including mid-CALCULA, force OCIOSO with s=0, cout=0, ov=0, zero=0, ocupado=0 and pronto=0, discarding the operation in progress.
REQ-030 After rst_n deasserts, the first inicio SHALL be accepted at the first rising edge.

Verification (LARGURA=8, LARGURA_B=4, DIGITO=2, N=4)
REQ-031 a=05, b=3, modo_sub=0, cin=0 -> pronto 5 cycles after the sampling edge; s=08, cout=0, ov=0, zero=0; ocupado high for 5 cycles.
REQ-032 a=05, b=3, modo_sub=1, cin=1 -> s=02, cout=1, ov=0, zero=0.
REQ-033 a=7F, b=1, modo_sub=0, cin=0 -> s=80, cout=0, ov=1; a=03, b=3, modo_sub=1, cin=1 -> s=00, cout=1, zero=1.
REQ-034 After s=08, acumular=1, b=F, modo_sub=0, cin=0, a=AA -> s=17 (port a ignored).
REQ-035 Pulse inicio again during CALCULA -> ignored, with exactly one pronto; then rst_n=0 mid-CALCULA -> all outputs 0 immediately, and no pronto after release.
